// File: rtl/fu_div_pkg.sv
// Shared definitions for the RV32M iterative divide unit: op encodings,
// FSM state type and the write-back scheduling constants.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_e;

  // Issue-to-result latency, and the write-back slot the control unit reads at.
  localparam int unsigned DIV_LATENCY = 17;
  localparam int unsigned DIV_SLOT    = 24;

endpackage

// File: rtl/fu_div_if.sv
// Issue/result bundle between the control unit (master) and the divider (slave).
interface fu_div_if #(
  parameter int unsigned XLEN = 32
);

  logic            EN;
  logic [1:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] res;
  logic            finish;
  logic            busy;

  modport master (
    output EN, op, A, B,
    input  res, finish, busy
  );

  modport slave (
    input  EN, op, A, B,
    output res, finish, busy
  );

endinterface

// File: rtl/fu_div_step.sv
// One combinational restoring-division step on {remainder, quotient}.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN:0]   dvs,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // One extra bit on the trial subtract so its MSB is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[XLEN+1]) begin
      rem_out = shifted[XLEN:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = diff[XLEN:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/fu_div.sv
// Fixed-latency iterative divider for DIV/DIVU/REM/REMU; BITS_PER_CYC
// quotient bits per cycle, result held in res until the next completion.
module fu_div
  import div_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BITS_PER_CYC = 2
) (
  input logic     clk,
  input logic     rst,
  fu_div_if.slave dif
);

  localparam int unsigned ITERS = XLEN / BITS_PER_CYC;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  if (DIV_LATENCY > DIV_SLOT) begin : g_slot_chk
    $error("fu_div: DIV_LATENCY exceeds DIV_SLOT");
  end
  if (XLEN != 32 || (XLEN % BITS_PER_CYC) != 0) begin : g_param_chk
    $error("fu_div: unsupported XLEN/BITS_PER_CYC");
  end

  div_state_e state, state_next;
  logic       start;

  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  b_mag;
  logic [XLEN-1:0]  a_orig;
  logic             is_rem;
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic             ovf;
  logic [XLEN-1:0]  res_q;
  logic             finish_q;

  logic             op_signed;
  logic             op_rem;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;
  logic [XLEN-1:0]  res_next;

  logic [XLEN:0]    rem_c [0:BITS_PER_CYC];
  logic [XLEN-1:0]  quo_c [0:BITS_PER_CYC];

  assign rem_c[0] = rem;
  assign quo_c[0] = quo;

  for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_c[i]),
      .quo_in  (quo_c[i]),
      .dvs     ({1'b0, b_mag}),
      .rem_out (rem_c[i+1]),
      .quo_out (quo_c[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A new issue is accepted in IDLE and in the FIX cycle, never during CALC.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        start = dif.EN;
        if (dif.EN) state_next = CALC;
      end
      CALC: begin
        if (cnt == CNT_LAST) state_next = FIX;
      end
      FIX: begin
        start      = dif.EN;
        state_next = dif.EN ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    op_signed = (dif.op == DIV_OP_DIV) || (dif.op == DIV_OP_REM);
    op_rem    = (dif.op == DIV_OP_REM) || (dif.op == DIV_OP_REMU);
  end

  always_comb begin
    quo_fix = q_neg ? ('0 - quo) : quo;
    rem_fix = XLEN'(r_neg ? ({(XLEN+1){1'b0}} - rem) : rem);
    if (dz) begin
      quo_fix = '1;
      rem_fix = a_orig;
    end else if (ovf) begin
      quo_fix = {1'b1, {(XLEN-1){1'b0}}};
      rem_fix = '0;
    end
    res_next = is_rem ? rem_fix : quo_fix;
  end

  // Result write-back in FIX and operand latch for a new issue share one
  // edge; non-blocking updates keep the old operation's values for res.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      b_mag    <= '0;
      a_orig   <= '0;
      is_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      res_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (state == FIX) begin
        res_q    <= res_next;
        finish_q <= 1'b1;
      end
      if (start) begin
        cnt    <= '0;
        rem    <= '0;
        quo    <= (op_signed && dif.A[XLEN-1]) ? ('0 - dif.A) : dif.A;
        b_mag  <= (op_signed && dif.B[XLEN-1]) ? ('0 - dif.B) : dif.B;
        a_orig <= dif.A;
        is_rem <= op_rem;
        q_neg  <= op_signed && (dif.A[XLEN-1] ^ dif.B[XLEN-1]);
        r_neg  <= op_signed && dif.A[XLEN-1];
        dz     <= (dif.B == '0);
        ovf    <= op_signed && (dif.A == {1'b1, {(XLEN-1){1'b0}}}) && (dif.B == '1);
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        rem <= rem_c[BITS_PER_CYC];
        quo <= quo_c[BITS_PER_CYC];
      end
    end
  end

  assign dif.res    = res_q;
  assign dif.finish = finish_q;
  assign dif.busy   = (state != IDLE);

endmodule

// File: tb/tb_fu_div.sv
// Scoreboard bench for fu_div: issues directed and random divides, a monitor
// checks result, latency, hold and busy against an arithmetic reference.
module tb_fu_div;

  localparam int unsigned LAT = 17;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   finish_cnt = 0;
  bit   allow_illegal = 1'b0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          iss;
    string       name;
  } exp_t;

  exp_t scb[$];

  fu_div_if #(.XLEN(32)) dif ();

  fu_div #(.XLEN(32), .BITS_PER_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics written directly from the ISA rules.
  function automatic logic [31:0] ref_div(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    logic ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ov ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 40));
      5:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b, string name, bit track);
    @(negedge clk);
    dif.EN = 1'b1;
    dif.op = o;
    dif.A  = a;
    dif.B  = b;
    @(posedge clk);
    #1;
    if (track) scb.push_back('{res: ref_div(o, a, b), iss: cyc, name: name});
    dif.EN = 1'b0;
    dif.op = 2'($urandom);
    dif.A  = $urandom;
    dif.B  = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && scb.size() != 0; i++) @(posedge clk);
    if (scb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results outstanding, expected 0", scb.size());
      scb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_res = '0;
    end else begin
      bit in_fix;
      in_fix = (scb.size() != 0) && (cyc == scb[0].iss + int'(LAT) - 1);
      if (dif.EN && dif.busy && !in_fix && !allow_illegal) begin
        tests++;
        fails++;
        $display("FAIL illegal_issue: got EN while busy, expected no issue (cycle %0d)", cyc);
      end
      if (dif.finish) begin
        finish_cnt++;
        if (scb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_finish: got finish with res 0x%08h, expected none", dif.res);
        end else begin
          exp_t e;
          e = scb.pop_front();
          check({e.name, "_res"}, dif.res, e.res);
          check({e.name, "_latency"}, 32'(cyc - e.iss), LAT);
        end
        last_res = dif.res;
      end else begin
        check("res_hold", dif.res, last_res);
      end
      check("busy", {31'd0, dif.busy}, {31'd0, scb.size() != 0});
    end
  end

  initial begin
    int fc;
    rst    = 1'b1;
    dif.EN = 1'b0;
    dif.op = '0;
    dif.A  = '0;
    dif.B  = '0;
    repeat (3) @(negedge clk);
    check("reset_res", dif.res, 32'd0);
    check("reset_busy", {31'd0, dif.busy}, 32'd0);
    check("reset_finish", {31'd0, dif.finish}, 32'd0);
    rst = 1'b0;

    issue(2'b00, 32'd100, 32'd7, "div_100_7", 1);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1);
    wait_idle();
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, "divu_max_2", 1);
    wait_idle();
    issue(2'b01, 32'd5, 32'd0, "divu_by0", 1);
    wait_idle();
    issue(2'b10, 32'd5, 32'd0, "rem_by0", 1);
    wait_idle();
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1);
    wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1);
    wait_idle();

    // Second issue lands on the FIX edge of the first; a stray EN in CALC is ignored.
    issue(2'b00, 32'd20, 32'd3, "b2b_div_20_3", 1);
    repeat (16) @(posedge clk);
    issue(2'b01, 32'd9, 32'd4, "b2b_divu_9_4", 1);
    repeat (4) @(posedge clk);
    allow_illegal = 1'b1;
    issue(2'b00, 32'd1000, 32'd10, "ignored", 0);
    allow_illegal = 1'b0;
    wait_idle();

    // Abort mid-operation.
    issue(2'b00, 32'd50, 32'd5, "div_50_5_abort", 1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    scb.delete();
    #1;
    check("abort_res", dif.res, 32'd0);
    check("abort_busy", {31'd0, dif.busy}, 32'd0);
    check("abort_finish", {31'd0, dif.finish}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fc = finish_cnt;
    repeat (25) @(negedge clk);
    check("abort_no_finish", 32'(finish_cnt), 32'(fc));
    issue(2'b00, 32'd50, 32'd5, "div_50_5", 1);
    wait_idle();

    for (int n = 0; n < 80; n++) begin
      logic [1:0] o;
      o = 2'($urandom);
      issue(o, pick(), pick(), "rand", 1);
      repeat ($urandom_range(16, 20)) @(posedge clk);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
